// File: rtl/sim_test_finisher_pkg.sv
// Shared types for the simulation end-of-test controller.
// Status codes, FSM states and TL-UL opcode constants.
package sim_test_finisher_pkg;

  typedef enum logic [15:0] {
    BootRom = 16'hB090,
    InTest  = 16'h4354,
    InWfi   = 16'h1D1E,
    Passed  = 16'h900D,
    Failed  = 16'hBAAD
  } status_code_e;

  typedef enum logic [1:0] {
    Run,
    Drain,
    Done
  } fsm_e;

  localparam logic [2:0] TlPutFull    = 3'd0;
  localparam logic [2:0] TlPutPartial = 3'd1;

  typedef struct packed {
    logic        hit;
    logic        is_pass;
    logic        is_fail;
    logic [15:0] code;
  } status_dec_t;

endpackage

// File: rtl/sim_test_finisher_if.sv
// Snooped TL-UL A-channel write plus GPIO pins
// feeding the end-of-test controller.
interface sim_test_finisher_if;

  logic        tl_a_valid;
  logic        tl_a_ready;
  logic [2:0]  tl_a_opcode;
  logic [31:0] tl_a_address;
  logic [31:0] tl_a_data;
  logic [3:0]  tl_a_mask;
  logic [31:0] gpio_pins;

  modport master (
    output tl_a_valid,
    output tl_a_ready,
    output tl_a_opcode,
    output tl_a_address,
    output tl_a_data,
    output tl_a_mask,
    output gpio_pins
  );

  modport slave (
    input tl_a_valid,
    input tl_a_ready,
    input tl_a_opcode,
    input tl_a_address,
    input tl_a_data,
    input tl_a_mask,
    input gpio_pins
  );

endinterface

// File: rtl/sim_test_status_decode.sv
// Matches a status-word write on the snooped A channel
// and classifies the 16-bit code it carries.
module sim_test_status_decode
  import sim_test_finisher_pkg::*;
#(
  parameter logic [31:0] StatusAddr = 32'h0010_0000
) (
  input  logic        valid_i,
  input  logic        ready_i,
  input  logic [2:0]  opcode_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  mask_i,
  output status_dec_t dec_o
);

  logic        is_put;
  logic        hit;
  logic [15:0] code;
  logic        unused_bits;

  // Only the low half-word carries the code, so both low lanes must be written.
  assign is_put = (opcode_i == TlPutFull) ||
                  (opcode_i == TlPutPartial);
  assign hit    = valid_i && ready_i && is_put &&
                  (address_i[31:2] == StatusAddr[31:2]) &&
                  (mask_i[1:0] == 2'b11);
  assign code   = data_i[15:0];

  assign unused_bits = ^{data_i[31:16], address_i[1:0],
                         mask_i[3:2]};

  always_comb begin
    dec_o      = '0;
    dec_o.hit  = hit;
    dec_o.code = code;
    unique case (1'b1)
      hit && (code == Passed): dec_o.is_pass = 1'b1;
      hit && (code == Failed): dec_o.is_fail = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sim_test_finisher.sv
// End-of-test controller: status/GPIO/watchdog verdict,
// drain delay, then a single finish_req pulse.
module sim_test_finisher
  import sim_test_finisher_pkg::*;
#(
  parameter logic [31:0] StatusAddr    = 32'h0010_0000,
  parameter int unsigned DrainCycles   = 8,
  parameter logic [31:0] TimeoutCycles = 32'd0,
  parameter logic [31:0] LegacySig     = 32'hDEADBEEF
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  sim_test_finisher_if.slave bus,
  output logic [15:0]        status_o,
  output logic               test_done_o,
  output logic               test_passed_o,
  output logic               timed_out_o,
  output logic               finish_req_o
);

  localparam logic [31:0] DrainLoad = 32'(DrainCycles - 1);

  status_dec_t dec;
  fsm_e        state_q, state_d;
  logic [15:0] status_q, status_d;
  logic        done_q, done_d;
  logic        passed_q, passed_d;
  logic        tout_q, tout_d;
  logic        finish_q, finish_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] wdog_q, wdog_d;

  logic wdog_hit;
  logic gpio_hit;
  logic verdict;
  logic v_pass;
  logic v_tout;

  sim_test_status_decode #(
    .StatusAddr (StatusAddr)
  ) u_decode (
    .valid_i   (bus.tl_a_valid),
    .ready_i   (bus.tl_a_ready),
    .opcode_i  (bus.tl_a_opcode),
    .address_i (bus.tl_a_address),
    .data_i    (bus.tl_a_data),
    .mask_i    (bus.tl_a_mask),
    .dec_o     (dec)
  );

  assign wdog_hit = (TimeoutCycles != '0) &&
                    (wdog_q == TimeoutCycles - 32'd1);
  assign gpio_hit = (bus.gpio_pins == LegacySig);
  assign verdict  = dec.is_fail | dec.is_pass |
                    wdog_hit | gpio_hit;

  // Same-cycle verdicts: SW fail, SW pass, watchdog, legacy GPIO.
  always_comb begin
    v_pass = 1'b1;
    v_tout = 1'b0;
    priority case (1'b1)
      dec.is_fail: v_pass = 1'b0;
      dec.is_pass: v_pass = 1'b1;
      wdog_hit: begin
        v_pass = 1'b0;
        v_tout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= Run;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Run:     if (verdict) state_d = Drain;
      Drain:   if (drain_q == '0) state_d = Done;
      Done:    state_d = Done;
      default: state_d = Run;
    endcase
  end

  always_comb begin
    status_d = status_q;
    done_d   = done_q;
    passed_d = passed_q;
    tout_d   = tout_q;
    finish_d = 1'b0;
    drain_d  = drain_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      Run: begin
        if (wdog_q != '1) wdog_d = wdog_q + 32'd1;
        if (dec.hit) status_d = dec.code;
        if (verdict) begin
          done_d   = 1'b1;
          passed_d = v_pass;
          tout_d   = v_tout;
          drain_d  = DrainLoad;
        end
      end
      Drain: begin
        if (drain_q == '0) finish_d = 1'b1;
        else drain_d = drain_q - 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      status_q <= '0;
      done_q   <= 1'b0;
      passed_q <= 1'b0;
      tout_q   <= 1'b0;
      finish_q <= 1'b0;
      drain_q  <= '0;
      wdog_q   <= '0;
    end else begin
      status_q <= status_d;
      done_q   <= done_d;
      passed_q <= passed_d;
      tout_q   <= tout_d;
      finish_q <= finish_d;
      drain_q  <= drain_d;
      wdog_q   <= wdog_d;
    end
  end

  assign status_o      = status_q;
  assign test_done_o   = done_q;
  assign test_passed_o = passed_q;
  assign timed_out_o   = tout_q;
  assign finish_req_o  = finish_q;

  finish_pulse_a: assert property (
    @(posedge clk_sys) disable iff (!rst_sys_n)
    finish_req_o |=> !finish_req_o);

  finish_done_a: assert property (
    @(posedge clk_sys) disable iff (!rst_sys_n)
    finish_req_o |-> test_done_o);

  status_align_a: assert property (
    @(posedge clk_sys) StatusAddr[1:0] == 2'b00);

  drain_min_a: assert property (
    @(posedge clk_sys) DrainCycles >= 1);

endmodule

// File: tb/tb_sim_test_finisher.sv
// Bench for sim_test_finisher: directed scenarios plus
// randomized traffic against a rule-level model.
module tb_sim_test_finisher;

  localparam logic [31:0] SADDR = 32'h0010_0000;
  localparam int          DRAIN = 8;
  localparam int          TMO   = 100;
  localparam logic [31:0] SIG   = 32'hDEADBEEF;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_a_n;
  logic rst_b_n;

  sim_test_finisher_if bus_a ();
  sim_test_finisher_if bus_b ();

  logic [15:0] status_a, status_b;
  logic        done_a, done_b;
  logic        pass_a, pass_b;
  logic        tout_a, tout_b;
  logic        fin_a, fin_b;

  int checks   = 0;
  int failures = 0;

  sim_test_finisher #(
    .StatusAddr    (SADDR),
    .DrainCycles   (DRAIN),
    .TimeoutCycles (32'd0),
    .LegacySig     (SIG)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_sys_n     (rst_a_n),
    .bus           (bus_a),
    .status_o      (status_a),
    .test_done_o   (done_a),
    .test_passed_o (pass_a),
    .timed_out_o   (tout_a),
    .finish_req_o  (fin_a)
  );

  sim_test_finisher #(
    .StatusAddr    (SADDR),
    .DrainCycles   (DRAIN),
    .TimeoutCycles (32'(TMO)),
    .LegacySig     (SIG)
  ) dut_wd (
    .clk_sys       (clk_sys),
    .rst_sys_n     (rst_b_n),
    .bus           (bus_b),
    .status_o      (status_b),
    .test_done_o   (done_b),
    .test_passed_o (pass_b),
    .timed_out_o   (tout_b),
    .finish_req_o  (fin_b)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v,
                       input logic r, input logic [2:0] op,
                       input logic [31:0] ad,
                       input logic [31:0] d,
                       input logic [3:0] m,
                       input logic [31:0] g);
    if (!sel) begin
      bus_a.tl_a_valid   = v;
      bus_a.tl_a_ready   = r;
      bus_a.tl_a_opcode  = op;
      bus_a.tl_a_address = ad;
      bus_a.tl_a_data    = d;
      bus_a.tl_a_mask    = m;
      bus_a.gpio_pins    = g;
    end else begin
      bus_b.tl_a_valid   = v;
      bus_b.tl_a_ready   = r;
      bus_b.tl_a_opcode  = op;
      bus_b.tl_a_address = ad;
      bus_b.tl_a_data    = d;
      bus_b.tl_a_mask    = m;
      bus_b.gpio_pins    = g;
    end
  endtask

  task automatic idle(input bit sel);
    drive(sel, 0, 0, 3'd0, 32'h0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic put(input bit sel, input logic [31:0] d);
    drive(sel, 1, 1, 3'd0, SADDR, d, 4'hF, 32'h0);
  endtask

  task automatic reset_a();
    idle(0);
    rst_a_n = 1'b0;
    tick();
    tick();
    rst_a_n = 1'b1;
  endtask

  task automatic reset_b();
    idle(1);
    rst_b_n = 1'b0;
    tick();
    tick();
    rst_b_n = 1'b1;
  endtask

  // Edge index (1-based, after the call) of the first finish pulse on dut.
  task automatic watch_fin_a(input int n, output int first,
                             output int pulses);
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (fin_a === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic test_reset();
    idle(0);
    idle(1);
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({status_a, done_a, pass_a, tout_a, fin_a} !== 20'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0",
               {status_a, done_a, pass_a, tout_a, fin_a});
    end
    checks++;
    if ({status_b, done_b, pass_b, tout_b, fin_b} !== 20'h0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0",
               {status_b, done_b, pass_b, tout_b, fin_b});
    end
    rst_a_n = 1'b1;
    tick();
    checks++;
    if ({status_a, done_a, fin_a} !== 18'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=0",
               {status_a, done_a, fin_a});
    end
  endtask

  task automatic test_pass_sequence();
    int first;
    int pulses;
    reset_a();
    put(0, 32'h0000_4354);
    tick();
    checks++;
    if (status_a !== 16'h4354 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL intest status=%h done=%b exp=4354/0",
               status_a, done_a);
    end
    put(0, 32'hA5A5_900D);
    tick();
    checks++;
    if (status_a !== 16'h900D) begin
      failures++;
      $display("FAIL pass_status got=%h exp=900d", status_a);
    end
    checks++;
    if ({done_a, pass_a, tout_a, fin_a} !== 4'b1100) begin
      failures++;
      $display("FAIL pass_verdict got=%b exp=1100",
               {done_a, pass_a, tout_a, fin_a});
    end
    idle(0);
    watch_fin_a(DRAIN + 4, first, pulses);
    checks++;
    if (first !== DRAIN || pulses !== 1) begin
      failures++;
      $display("FAIL pass_finish at=%0d n=%0d exp=%0d/1",
               first, pulses, DRAIN);
    end
  endtask

  task automatic test_ready_stall();
    int first;
    int pulses;
    reset_a();
    drive(0, 1, 0, 3'd0, SADDR, 32'h0000_BAAD, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_a !== 1'b0 || status_a !== 16'h0) begin
        failures++;
        $display("FAIL stall_%0d done=%b status=%h exp=0/0",
                 i, done_a, status_a);
      end
    end
    bus_a.tl_a_ready = 1'b1;
    tick();
    checks++;
    if ({done_a, pass_a} !== 2'b10 || status_a !== 16'hBAAD) begin
      failures++;
      $display("FAIL stall_fail done/pass=%b status=%h exp=10/baad",
               {done_a, pass_a}, status_a);
    end
    idle(0);
    watch_fin_a(DRAIN + 4, first, pulses);
    checks++;
    if (first !== DRAIN || pulses !== 1) begin
      failures++;
      $display("FAIL stall_finish at=%0d n=%0d exp=%0d/1",
               first, pulses, DRAIN);
    end
  endtask

  task automatic test_ignored();
    reset_a();
    for (int i = 0; i < 4; i++) begin
      unique case (i)
        0: drive(0, 1, 1, 3'd0, SADDR + 32'd4,
                 32'h900D, 4'hF, 32'h0);
        1: drive(0, 1, 1, 3'd0, SADDR, 32'h900D, 4'hC, 32'h0);
        2: drive(0, 1, 1, 3'd4, SADDR, 32'h900D, 4'hF, 32'h0);
        default: drive(0, 1, 1, 3'd1, SADDR, 32'hBAAD,
                       4'h1, 32'h0);
      endcase
      tick();
      checks++;
      if (status_a !== 16'h0 || done_a !== 1'b0) begin
        failures++;
        $display("FAIL ignored_%0d status=%h done=%b exp=0/0",
                 i, status_a, done_a);
      end
    end
    drive(0, 1, 1, 3'd1, SADDR + 32'd2, 32'h1D1E, 4'h3, 32'h0);
    tick();
    idle(0);
    checks++;
    if (status_a !== 16'h1D1E || done_a !== 1'b0) begin
      failures++;
      $display("FAIL partial_hit status=%h done=%b exp=1d1e/0",
               status_a, done_a);
    end
  endtask

  task automatic test_legacy();
    int first;
    int pulses;
    reset_a();
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 4'h0, SIG);
    tick();
    checks++;
    if ({done_a, pass_a, tout_a} !== 3'b110 || status_a !== 16'h0) begin
      failures++;
      $display("FAIL legacy got=%b status=%h exp=110/0",
               {done_a, pass_a, tout_a}, status_a);
    end
    put(0, 32'h0000_BAAD);
    tick();
    idle(0);
    checks++;
    if (pass_a !== 1'b1 || status_a !== 16'h0) begin
      failures++;
      $display("FAIL legacy_hold pass=%b status=%h exp=1/0",
               pass_a, status_a);
    end
    watch_fin_a(DRAIN + 4, first, pulses);
    checks++;
    if (first !== DRAIN - 1 || pulses !== 1) begin
      failures++;
      $display("FAIL legacy_finish at=%0d n=%0d exp=%0d/1",
               first, pulses, DRAIN - 1);
    end
  endtask

  // Count reaches TMO-1 after TMO-1 edges; the verdict lands on edge TMO.
  task automatic test_watchdog();
    int to_at;
    int fin_at;
    int pulses;
    reset_b();
    to_at  = -1;
    fin_at = -1;
    pulses = 0;
    for (int e = 1; e <= TMO + DRAIN + 6; e++) begin
      tick();
      if (tout_b === 1'b1 && to_at < 0) to_at = e;
      if (fin_b === 1'b1) begin
        pulses++;
        if (fin_at < 0) fin_at = e;
      end
      if (e == TMO) begin
        checks++;
        if ({done_b, pass_b} !== 2'b10) begin
          failures++;
          $display("FAIL wdog_verdict got=%b exp=10",
                   {done_b, pass_b});
        end
      end
    end
    checks++;
    if (to_at !== TMO) begin
      failures++;
      $display("FAIL wdog_time at=%0d exp=%0d", to_at, TMO);
    end
    checks++;
    if (fin_at !== TMO + DRAIN || pulses !== 1) begin
      failures++;
      $display("FAIL wdog_finish at=%0d n=%0d exp=%0d/1",
               fin_at, pulses, TMO + DRAIN);
    end
  endtask

  task automatic test_watchdog_race();
    int fin_at;
    int pulses;
    reset_b();
    for (int e = 1; e < TMO; e++) tick();
    checks++;
    if (done_b !== 1'b0) begin
      failures++;
      $display("FAIL race_early done=%b exp=0", done_b);
    end
    put(1, 32'h0000_900D);
    tick();
    idle(1);
    checks++;
    if ({done_b, pass_b, tout_b} !== 3'b110) begin
      failures++;
      $display("FAIL race_verdict got=%b exp=110",
               {done_b, pass_b, tout_b});
    end
    fin_at = -1;
    pulses = 0;
    for (int k = 1; k <= DRAIN + 4; k++) begin
      tick();
      if (fin_b === 1'b1) begin
        pulses++;
        if (fin_at < 0) fin_at = k;
      end
    end
    checks++;
    if (fin_at !== DRAIN || pulses !== 1 || tout_b !== 1'b0) begin
      failures++;
      $display("FAIL race_finish at=%0d n=%0d tout=%b exp=%0d/1/0",
               fin_at, pulses, tout_b, DRAIN);
    end
  endtask

  task automatic test_reset_in_drain();
    int first;
    int pulses;
    reset_a();
    put(0, 32'h0000_900D);
    tick();
    idle(0);
    tick();
    tick();
    tick();
    rst_a_n = 1'b0;
    #1;
    checks++;
    if ({status_a, done_a, pass_a, tout_a, fin_a} !== 20'h0) begin
      failures++;
      $display("FAIL abort_outputs got=%h exp=0",
               {status_a, done_a, pass_a, tout_a, fin_a});
    end
    tick();
    tick();
    rst_a_n = 1'b1;
    watch_fin_a(DRAIN + 4, first, pulses);
    checks++;
    if (pulses !== 0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet n=%0d done=%b exp=0/0",
               pulses, done_a);
    end
    put(0, 32'h0000_BAAD);
    tick();
    idle(0);
    checks++;
    if ({done_a, pass_a} !== 2'b10) begin
      failures++;
      $display("FAIL abort_refail got=%b exp=10", {done_a, pass_a});
    end
    watch_fin_a(DRAIN + 4, first, pulses);
    checks++;
    if (first !== DRAIN || pulses !== 1) begin
      failures++;
      $display("FAIL abort_finish at=%0d n=%0d exp=%0d/1",
               first, pulses, DRAIN);
    end
  endtask

  task automatic test_random();
    logic        v, r, hit;
    logic [2:0]  op;
    logic [31:0] ad, d, g;
    logic [3:0]  m;
    logic [15:0] code;
    logic [15:0] m_status;
    logic        m_done, m_pass, exp_fin;
    int          v_edge;
    for (int t = 0; t < 6; t++) begin
      reset_a();
      m_status = '0;
      m_done   = 1'b0;
      m_pass   = 1'b0;
      v_edge   = -1;
      for (int e = 1; e <= 40; e++) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       op = 3'd0;
          1:       op = 3'd1;
          2:       op = 3'd4;
          default: op = 3'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0, 1:    ad = SADDR | 32'($urandom_range(0, 3));
          2:       ad = SADDR + 32'd4;
          default: ad = $urandom;
        endcase
        m = 4'($urandom);
        case ($urandom_range(0, 9))
          0:       code = 16'h900D;
          1:       code = 16'hBAAD;
          2:       code = 16'h4354;
          3:       code = 16'hB090;
          4:       code = 16'h1D1E;
          default: code = 16'($urandom);
        endcase
        d = {16'($urandom), code};
        g = ($urandom_range(0, 31) == 0) ? SIG : $urandom;
        drive(0, v, r, op, ad, d, m, g);
        hit = v && r && (op == 3'd0 || op == 3'd1) &&
              ((ad >> 2) == (SADDR >> 2)) &&
              ((m & 4'h3) == 4'h3);
        if (!m_done) begin
          if (hit) m_status = code;
          if (hit && code == 16'hBAAD) begin
            m_done = 1'b1;
            m_pass = 1'b0;
          end else if (hit && code == 16'h900D) begin
            m_done = 1'b1;
            m_pass = 1'b1;
          end else if (g == SIG) begin
            m_done = 1'b1;
            m_pass = 1'b1;
          end
          if (m_done) v_edge = e;
        end
        exp_fin = (v_edge >= 0) && (e == v_edge + DRAIN);
        tick();
        checks++;
        if (status_a !== m_status) begin
          failures++;
          $display("FAIL rnd_status t=%0d e=%0d got=%h exp=%h",
                   t, e, status_a, m_status);
        end
        checks++;
        if ({done_a, pass_a, tout_a, fin_a} !==
            {m_done, m_pass, 1'b0, exp_fin}) begin
          failures++;
          $display("FAIL rnd_flags t=%0d e=%0d got=%b exp=%b",
                   t, e, {done_a, pass_a, tout_a, fin_a},
                   {m_done, m_pass, 1'b0, exp_fin});
        end
      end
    end
    idle(0);
  endtask

  initial begin
    test_reset();
    test_pass_sequence();
    test_ready_stall();
    test_ignored();
    test_legacy();
    test_watchdog();
    test_watchdog_race();
    test_reset_in_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
